memory_row_streamer: RTL and testbench
======================================

// Module: memory_row_streamer
// PURPOSE
//   Moves whole 16-word rows between the 64kx16 memory block's 256-bit row
//   port and a 16-bit valid/ready word stream used by devices.
//   Read command: fetches one row, then emits its words in order.
//   Write command: collects 16 stream words, then writes them as one row
//   (single row_write pulse). Sits beside the CPU, driving the memory's
//   portB_address/row_data/row_write and consuming row_data_out.
// PARAMETERS
//   WORDS_PER_ROW  16  words per row; row width = 16*WORDS_PER_ROW bits
//   ADDR_WIDTH     16  memory word address width
//   READ_LATENCY   1   cycles from mem_address change to valid mem_row_data_out
// PORTS
//   clock             in   1     system clock, all logic on rising edge
//   reset             in   1     synchronous, active-high
//   cmd_valid         in   1     command offered
//   cmd_ready         out  1     command accepted when cmd_valid & cmd_ready
//   cmd_write         in   1     0 = memory->stream, 1 = stream->memory
//   cmd_address       in   ADDR_WIDTH   row address passed to memory unmodified
//   busy              out  1     high from accept until done
//   done              out  1     one-cycle pulse at end of command
//   mem_address       out  ADDR_WIDTH   to memory portB_address
//   mem_row_write     out  1     to memory row_write
//   mem_row_data      out  256   to memory row_data
//   mem_row_data_out  in   256   from memory row_data_out
//   out_data          out  16    stream word to device
//   out_valid         out  1
//   out_ready         in   1
//   in_data           in   16    stream word from device
//   in_valid          in   1
//   in_ready          out  1
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready=1, busy=0, done=0, mem_row_write=0,
//     out_valid=0, in_ready=0; mem_address, mem_row_data, out_data = 0.
//   States: IDLE, FETCH, SEND, RECV, WRITE, DONE.
//   IDLE: cmd_ready=1. On cmd_valid, latch cmd_address into mem_address and
//     cmd_write; word count = 0. Go to FETCH (read) or RECV (write).
//   FETCH: wait READ_LATENCY cycles, then capture mem_row_data_out into the
//     row buffer; go to SEND.
//   SEND: out_valid=1, out_data = buffer word[count] (word 0 = bits 15:0).
//     out_data is held stable while out_ready=0. On handshake, count+1;
//     after word WORDS_PER_ROW-1, go to DONE.
//   RECV: in_ready=1. On handshake, store in_data at buffer word[count] and
//     count+1; after word WORDS_PER_ROW-1, go to WRITE.
//   WRITE: mem_row_write=1 for exactly one cycle; mem_row_data = buffer.
//     Go to DONE.
//   DONE: done=1 for one cycle, busy=0 next cycle; return to IDLE.
//   Output rules: cmd_ready only in IDLE; busy in every state except IDLE;
//     out_valid only in SEND; in_ready only in RECV.
//   mem_address is held constant from accept until IDLE; mem_row_data
//     changes only in RECV.
//   Timing (accept at cycle T, READ_LATENCY=1, ready always high): first
//     out_valid at T+2; last word at T+17; done at T+18.
//     Write: last in handshake at W; mem_row_write at W+1; done at W+2.
//   Counter width = clog2(WORDS_PER_ROW); no wrap. The last-word check ends
//     the transfer.
//   cmd_valid outside IDLE is ignored, not queued.
//   Reset mid-command: return to IDLE immediately. No row_write is issued
//     and partial receive data is discarded.
// TESTING
//   Read: mem_row_data_out word k = 16'hA000+k, cmd read @0x0040, out_ready=1
//     -> words A000..A00F on consecutive cycles, done at T+18, no row_write.
//   Write: stream 16'h1000..100F -> single mem_row_write with
//     mem_row_data[15:0]=1000, [255:240]=100F, and mem_address = cmd_address.
//   Backpressure: toggle out_ready every cycle on read -> each word held until
//     accepted; 16 words delivered in order, none dropped or duplicated.
//   Sparse input: in_valid 1-in-3 on write -> row_write only after 16th word;
//     in_ready low in every non-RECV cycle.
//   Reset after 7 received words, then new read -> no row_write; outputs at
//     reset values; the following command runs normally.
//   cmd_valid held high across a command -> accepted only in IDLE; second
//     command starts the cycle after done.

Source files
------------

// File: rtl/memory_row_streamer.sv
// memory_row_streamer
// Moves whole rows between the wide row port of the memory block and a
// 16-bit valid/ready word stream. A read command fetches one row and emits
// its words lowest-first; a write command gathers one row of stream words
// and commits it with a single row_write pulse.
module memory_row_streamer #(
    parameter int WORDS_PER_ROW = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [ADDR_WIDTH-1:0]         cmd_address,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_row_write,
    output logic [16*WORDS_PER_ROW-1:0]   mem_row_data,
    input  logic [16*WORDS_PER_ROW-1:0]   mem_row_data_out,
    output logic [15:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic [15:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready
);

    localparam int CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);
    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]                 count;
    logic [LAT_W-1:0]                 lat_cnt;
    logic [WORDS_PER_ROW-1:0][15:0]   rd_buf;
    logic [WORDS_PER_ROW-1:0][15:0]   wr_buf;

    logic last_word;
    logic lat_done;

    assign last_word    = (count == LAST_WORD);
    assign lat_done     = (lat_cnt == LAST_LAT);
    // The write buffer doubles as the row presented to memory, so it only
    // moves while words are being received.
    assign mem_row_data = wr_buf;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore outputs; every output depends on state only
    // (plus the buffered word), so nothing combinational passes from the
    // stream inputs to the stream outputs.
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mem_row_write = 1'b0;
        out_valid     = 1'b0;
        in_ready      = 1'b0;
        out_data      = 16'h0000;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = cmd_write ? RECV : FETCH;
                end
            end
            FETCH: begin
                if (lat_done) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = rd_buf[count];
                if (out_ready && last_word) begin
                    state_next = DONE;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                if (in_valid && last_word) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_row_write = 1'b1;
                state_next    = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: address latch, word counter, fetch delay and row buffers.
    // The counter stops on the last word instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            lat_cnt     <= '0;
            mem_address <= '0;
            rd_buf      <= '0;
            wr_buf      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count   <= '0;
                    lat_cnt <= '0;
                    if (cmd_valid) begin
                        mem_address <= cmd_address;
                    end
                end
                FETCH: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_done) begin
                        rd_buf <= mem_row_data_out;
                    end
                end
                SEND: begin
                    if (out_ready && !last_word) begin
                        count <= count + CNT_W'(1);
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        wr_buf[count] <= in_data;
                        if (!last_word) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_row_streamer.sv
// Self-checking bench for memory_row_streamer: a table of directed commands,
// hand-written reset and back-to-back command sequences, and randomized
// commands checked against a queue/array model of the row transfer.
module tb_memory_row_streamer;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [15:0]  cmd_address;
    logic         busy;
    logic         done;
    logic [15:0]  mem_address;
    logic         mem_row_write;
    logic [255:0] mem_row_data;
    logic [255:0] row_src;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;

    memory_row_streamer #(
        .WORDS_PER_ROW(16),
        .ADDR_WIDTH   (16),
        .READ_LATENCY (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .busy            (busy),
        .done            (done),
        .mem_address     (mem_address),
        .mem_row_write   (mem_row_write),
        .mem_row_data    (mem_row_data),
        .mem_row_data_out(row_src),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory-side observers: row writes and command acceptances.
    int           wr_pulses = 0;
    int           accepts   = 0;
    logic [255:0] wr_data   = '0;
    logic [15:0]  wr_addr   = '0;
    always @(posedge clock) begin
        if (!reset && mem_row_write) begin
            wr_pulses <= wr_pulses + 1;
            wr_data   <= mem_row_data;
            wr_addr   <= mem_address;
        end
        if (!reset && cmd_valid && cmd_ready) begin
            accepts <= accepts + 1;
        end
    end

    // Transaction model state and results of the last command.
    logic [15:0] tx_words [16];
    logic [15:0] rx_q [$];
    int rel_first_valid, rel_done, rel_last_in, rel_last_out, rel_wr;
    int n_in_ready, n_wr_cycles;
    bit hold_ok, busy_ok, addr_ok;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] base;
        int          mode;
        int          exp_first;
        int          exp_done;
        logic [15:0] exp_w0;
        logic [15:0] exp_wl;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_row();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[16*k +: 16] = tx_words[k];
        end
        return r;
    endfunction

    function automatic bit stream_matches();
        if (rx_q.size() != 16) return 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (rx_q[k] !== tx_words[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] rx_last();
        if (rx_q.size() == 0) return 16'hxxxx;
        return rx_q[rx_q.size()-1];
    endfunction

    // Issue one command from an IDLE cycle and follow it until done.
    // mode 0: ready/valid always high; 1: out_ready toggles, in_valid 1-in-3;
    // 2: random. Cycle numbers are relative to the accepting cycle T.
    task automatic run_cmd(input logic wr, input logic [15:0] addr, input int mode, input bit keep);
        int   rel;
        int   sent;
        bit   prev_stall;
        logic [15:0] prev_data;
        rx_q.delete();
        rel_first_valid = -1; rel_done = -1; rel_last_in = -1;
        rel_last_out = -1; rel_wr = -1;
        n_in_ready = 0; n_wr_cycles = 0;
        hold_ok = 1'b1; busy_ok = 1'b1; addr_ok = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = addr;
        chk("cmd_ready_in_idle", cmd_ready, 1'b1);
        @(posedge clock); #1;
        if (!keep) cmd_valid = 1'b0;
        rel = 1; sent = 0; prev_stall = 1'b0; prev_data = '0;
        while (rel_done < 0 && rel < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = rel[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (wr && sent < 16) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (rel % 3 == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data = tx_words[sent];
            end else begin
                in_valid = 1'b0;
                in_data  = 16'h0000;
            end
            if (prev_stall && !(out_valid && out_data === prev_data)) hold_ok = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (mem_address !== addr) addr_ok = 1'b0;
            if (out_valid && rel_first_valid < 0) rel_first_valid = rel;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rel_last_out = rel;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_ready) n_in_ready++;
            if (in_ready && in_valid) begin
                sent++;
                rel_last_in = rel;
            end
            if (mem_row_write) begin
                n_wr_cycles++;
                rel_wr = rel;
            end
            if (done) rel_done = rel;
            @(posedge clock); #1;
            rel++;
        end
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wp0;
        int   acc0;
        int   sent;
        int   guard;
        logic rwr;
        logic [15:0] raddr;

        vecs[0] = '{1'b0, 16'h0040, 16'hA000, 0,  2, 18, 16'hA000, 16'hA00F};
        vecs[1] = '{1'b0, 16'h1230, 16'h5500, 1,  2, 34, 16'h5500, 16'h550F};
        vecs[2] = '{1'b1, 16'h0080, 16'h1000, 0, -1, 18, 16'h1000, 16'h100F};
        vecs[3] = '{1'b1, 16'hFFF0, 16'h2000, 1, -1, 50, 16'h2000, 16'h200F};
        vecs[4] = '{1'b0, 16'hFFFF, 16'hFFF0, 0,  2, 18, 16'hFFF0, 16'hFFFF};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        out_ready = 1'b1; in_valid = 1'b0; in_data = '0; row_src = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_row_write", mem_row_write, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_address", mem_address, 16'h0000);
        chk("rst_mem_row_data", mem_row_data, 256'h0);
        chk("rst_out_data", out_data, 16'h0000);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed command table.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 16; k++) tx_words[k] = vecs[i].base + 16'(k);
            row_src = pack_row();
            wp0 = wr_pulses;
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].mode, 1'b0);
            chk($sformatf("v%0d_done_cycle", i), rel_done, vecs[i].exp_done);
            chk($sformatf("v%0d_first_valid", i), rel_first_valid, vecs[i].exp_first);
            chk($sformatf("v%0d_addr_held", i), addr_ok, 1'b1);
            chk($sformatf("v%0d_busy", i), busy_ok, 1'b1);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_write_pulses", i), wr_pulses - wp0, 1);
                chk($sformatf("v%0d_row_word0", i), wr_data[15:0], vecs[i].exp_w0);
                chk($sformatf("v%0d_row_word15", i), wr_data[255:240], vecs[i].exp_wl);
                chk($sformatf("v%0d_row", i), wr_data, pack_row());
                chk($sformatf("v%0d_write_addr", i), wr_addr, vecs[i].addr);
                chk($sformatf("v%0d_write_cycle", i), rel_wr, rel_last_in + 1);
                chk($sformatf("v%0d_in_ready_cycles", i), n_in_ready, rel_last_in);
            end else begin
                chk($sformatf("v%0d_no_write", i), wr_pulses - wp0, 0);
                chk($sformatf("v%0d_word_count", i), rx_q.size(), 16);
                chk($sformatf("v%0d_first_word", i), (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, vecs[i].exp_w0);
                chk($sformatf("v%0d_last_word", i), rx_last(), vecs[i].exp_wl);
                chk($sformatf("v%0d_stream", i), stream_matches(), 1'b1);
                chk($sformatf("v%0d_hold", i), hold_ok, 1'b1);
                chk($sformatf("v%0d_in_ready_low", i), n_in_ready, 0);
            end
            chk($sformatf("v%0d_idle_ready", i), cmd_ready, 1'b1);
            chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
        end

        // Reset after seven received words, then a normal read.
        wp0 = wr_pulses;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'h1234;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        sent = 0; guard = 0;
        while (sent < 7 && guard < 50) begin
            in_data = 16'hBEE0 + 16'(sent);
            if (in_ready) sent++;
            guard++;
            @(posedge clock); #1;
        end
        chk("rst_mid_words_taken", sent, 7);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b0);
        chk("rst_mid_row_write", mem_row_write, 1'b0);
        chk("rst_mid_mem_address", mem_address, 16'h0000);
        chk("rst_mid_row_data", mem_row_data, 256'h0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mid_no_write", wr_pulses - wp0, 0);
        for (int k = 0; k < 16; k++) tx_words[k] = 16'h7700 + 16'(k);
        row_src = pack_row();
        run_cmd(1'b0, 16'h0777, 0, 1'b0);
        chk("after_rst_done_cycle", rel_done, 18);
        chk("after_rst_stream", stream_matches(), 1'b1);
        chk("after_rst_no_write", wr_pulses - wp0, 0);

        // cmd_valid held high: no queuing, next accept right after done.
        acc0 = accepts;
        for (int k = 0; k < 16; k++) tx_words[k] = 16'h3300 + 16'(k);
        row_src = pack_row();
        run_cmd(1'b0, 16'h0100, 0, 1'b1);
        chk("held_valid_one_accept", accepts - acc0, 1);
        chk("held_valid_done_cycle", rel_done, 18);
        run_cmd(1'b0, 16'h0200, 0, 1'b0);
        chk("held_valid_second_accept", accepts - acc0, 2);
        chk("held_valid_second_done", rel_done, 18);
        chk("held_valid_second_addr", addr_ok, 1'b1);
        chk("held_valid_second_stream", stream_matches(), 1'b1);

        // Randomized commands against the transfer model.
        for (int t = 0; t < 8; t++) begin
            rwr   = 1'($urandom_range(0, 1));
            raddr = 16'($urandom);
            for (int k = 0; k < 16; k++) tx_words[k] = 16'($urandom);
            row_src = pack_row();
            wp0 = wr_pulses;
            run_cmd(rwr, raddr, 2, 1'b0);
            chk($sformatf("r%0d_addr_held", t), addr_ok, 1'b1);
            if (rwr) begin
                chk($sformatf("r%0d_write_pulses", t), wr_pulses - wp0, 1);
                chk($sformatf("r%0d_row", t), wr_data, pack_row());
                chk($sformatf("r%0d_write_addr", t), wr_addr, raddr);
                chk($sformatf("r%0d_done_cycle", t), rel_done, rel_last_in + 2);
            end else begin
                chk($sformatf("r%0d_stream", t), stream_matches(), 1'b1);
                chk($sformatf("r%0d_hold", t), hold_ok, 1'b1);
                chk($sformatf("r%0d_no_write", t), wr_pulses - wp0, 0);
                chk($sformatf("r%0d_done_cycle", t), rel_done, rel_last_out + 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
